// File: rtl/nios_mm_copy_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nios_mm_copy_master_if
//  Description : Avalon-MM word bus between the copy master and a slave.
//                The master drives requests and write data. The slave returns
//                flow control and read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface nios_mm_copy_master_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [3:0]        byteenable;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic              readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/nios_mm_copy_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : nios_mm_copy_master
//  Description : Avalon-MM master that copies a block of 32-bit words, one
//                read followed by one write per word, from a source word
//                address to a destination word address.
//  Revision    : 1.0  initial release
// ============================================================================
module nios_mm_copy_master #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     words_done,
  nios_mm_copy_master_if.master bus
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_RD_REQ  = 3'd1;
  localparam logic [2:0] c_RD_WAIT = 3'd2;
  localparam logic [2:0] c_WR_REQ  = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] c_ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  c_LEN_ONE  = 1;
  localparam logic [LEN_W-1:0]  c_LEN_ZERO = 0;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_remaining;
  logic [LEN_W-1:0]  r_words_done;
  logic [31:0]       r_writedata;
  logic              w_start_ok;
  logic              w_wr_accept;
  logic              w_data_in;

  assign w_start_ok  = (r_state == c_IDLE) && start;
  assign w_wr_accept = (r_state == c_WR_REQ) && !bus.waitrequest;
  // Read data is only meaningful while the single outstanding read is pending.
  assign w_data_in   = (r_state == c_RD_WAIT) && bus.readdatavalid;

  // State register; reset abandons any copy in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection: one read then one write per word.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_next_state = (length == c_LEN_ZERO) ? c_DONE : c_RD_REQ;
        end
      end
      c_RD_REQ: begin
        if (!bus.waitrequest) begin
          w_next_state = c_RD_WAIT;
        end
      end
      c_RD_WAIT: begin
        if (bus.readdatavalid) begin
          w_next_state = c_WR_REQ;
        end
      end
      c_WR_REQ: begin
        if (!bus.waitrequest) begin
          w_next_state = (r_remaining == c_LEN_ONE) ? c_DONE : c_RD_REQ;
        end
      end
      c_DONE: begin
        w_next_state = c_IDLE;
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // Command capture, read-data latch and per-word pointer/progress update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
      r_writedata  <= '0;
    end else begin
      if (w_start_ok) begin
        r_src        <= src_addr;
        r_dst        <= dst_addr;
        r_remaining  <= length;
        r_words_done <= '0;
      end
      if (w_data_in) begin
        r_writedata <= bus.readdata;
      end
      // Pointers wrap naturally at the address width.
      if (w_wr_accept) begin
        r_src        <= r_src + c_ADDR_ONE;
        r_dst        <= r_dst + c_ADDR_ONE;
        r_remaining  <= r_remaining - c_LEN_ONE;
        r_words_done <= r_words_done + c_LEN_ONE;
      end
    end
  end

  // Bus and status outputs decoded from state so reset clears them at once.
  always_comb begin
    busy           = (r_state != c_IDLE);
    done           = (r_state == c_DONE);
    bus.read       = (r_state == c_RD_REQ);
    bus.write      = (r_state == c_WR_REQ);
    bus.address    = (r_state == c_WR_REQ) ? r_dst : r_src;
    bus.byteenable = 4'b1111;
    bus.writedata  = r_writedata;
    words_done     = r_words_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_mm_copy_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_nios_mm_copy_master
//  Description : Bench for the copy master: a 16-word memory slave with
//                optional stalls, extra latency and spurious readdatavalid,
//                plus a memcpy-style reference of the expected bus traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nios_mm_copy_master;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  src_addr;
  logic [3:0]  dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] words_done;

  nios_mm_copy_master_if #(.ADDR_W(4)) bus ();

  nios_mm_copy_master #(.ADDR_W(4), .LEN_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mem       [16];
  logic [31:0] model_mem [16];
  txn_t        exp_q[$];
  int          log_q[$];
  txn_t        t_cur;
  bit          stress = 0;
  bit          spurious = 0;
  bit          hold_writes = 0;
  bit          in_req = 0;
  bit          prev_stall = 0;
  bit          prev_done = 0;
  bit          any_req = 0;
  int          stall_left = 0;
  int          rdv_cnt = -1;
  int          w_acc = 0;
  int          done_pulses = 0;
  logic [3:0]  rd_addr = 4'd0;
  logic        p_read, p_write;
  logic [3:0]  p_addr;
  logic [31:0] p_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference: a plain sequential word copy; each word is one read then one write.
  task automatic model_push(input logic [3:0] s, input logic [3:0] d, input int n, input bit commit);
    logic [31:0] shadow [16];
    logic [3:0]  a, b;
    txn_t        t;
    shadow = model_mem;
    a = s;
    b = d;
    for (int i = 0; i < n; i++) begin
      t.is_wr = 1'b0; t.addr = a; t.data = 32'd0;      exp_q.push_back(t);
      t.is_wr = 1'b1; t.addr = b; t.data = shadow[a];  exp_q.push_back(t);
      shadow[b] = shadow[a];
      a = a + 4'd1;
      b = b + 4'd1;
    end
    if (commit) model_mem = shadow;
  endtask

  // Slave model and per-cycle compare, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata      = 32'd0;
      in_req = 0; stall_left = 0; rdv_cnt = -1; prev_stall = 0; prev_done = 0; w_acc = 0;
      exp_q.delete();
    end else begin
      chk("rw_exclusive", 32'(bus.read & bus.write), 32'd0);
      chk("words_done", 32'(words_done), 32'(w_acc));
      if (prev_stall) begin
        chk("stall_read",  32'(bus.read),    32'(p_read));
        chk("stall_write", 32'(bus.write),   32'(p_write));
        chk("stall_addr",  32'(bus.address), 32'(p_addr));
        chk("stall_wdata", bus.writedata,    p_wdata);
      end
      if (prev_done) chk("done_width", 32'(done), 32'd0);
      if (done) done_pulses++;
      prev_done = done;
      p_read = bus.read; p_write = bus.write; p_addr = bus.address; p_wdata = bus.writedata;

      bus.readdatavalid = 1'b0;
      bus.readdata      = 32'hDEADBEEF;
      if (rdv_cnt == 0) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = mem[rd_addr];
        rdv_cnt = -1;
      end else if (rdv_cnt > 0) begin
        rdv_cnt--;
      end else if (spurious && (bus.read || bus.write)) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = 32'hBAD0BAD0;
      end

      bus.waitrequest = 1'b0;
      prev_stall = 0;
      if (bus.read || bus.write) begin
        any_req = 1;
        chk("byteenable", 32'(bus.byteenable), 32'h0000000F);
        if (!in_req) begin
          in_req = 1;
          stall_left = stress ? int'($urandom_range(0, 3)) : 0;
        end
        if (bus.write && hold_writes) begin
          bus.waitrequest = 1'b1;
          prev_stall = 1;
        end else if (stall_left > 0) begin
          stall_left--;
          bus.waitrequest = 1'b1;
          prev_stall = 1;
        end else begin
          in_req = 0;
          log_q.push_back(int'(bus.address));
          if (exp_q.size() == 0) begin
            fail_now("txn_unexpected", $sformatf("got %s at %0d, required none",
                     bus.write ? "write" : "read", bus.address));
          end else begin
            t_cur = exp_q.pop_front();
            chk("txn_kind", 32'(bus.write),   32'(t_cur.is_wr));
            chk("txn_addr", 32'(bus.address), 32'(t_cur.addr));
            if (bus.write) chk("txn_wdata", bus.writedata, t_cur.data);
          end
          if (bus.write) begin
            mem[bus.address] = bus.writedata;
            w_acc++;
          end else begin
            rd_addr = bus.address;
            rdv_cnt = stress ? int'($urandom_range(0, 2)) : 0;
          end
        end
      end
    end
  end

  // One complete copy: issue the command, time done, then audit the result.
  task automatic run_copy(input logic [3:0] s, input logic [3:0] d, input int n, output int dcyc);
    int cyc;
    @(negedge clk);
    model_push(s, d, n, 1'b1);
    src_addr = s; dst_addr = d; length = 16'(n); start = 1'b1;
    @(posedge clk);
    w_acc = 0; done_pulses = 0; any_req = 0;
    log_q.delete();
    #1 start = 1'b0;
    chk("busy_cycle1", 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) fail_now("done_timeout", "done not seen within 400 cycles");
    dcyc = cyc;
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_pulses), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i), mem[i], model_mem[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int k;
    int wrap_exp[8];
    mem[0] = 32'h11111111; mem[1] = 32'h22222222;
    mem[2] = 32'h33333333; mem[3] = 32'h44444444;
    for (int i = 4; i < 16; i++) mem[i] = 32'h5A5A0000 + i;
    model_mem = mem;
    start = 1'b0; src_addr = 4'd0; dst_addr = 4'd0; length = 16'd0;
    bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = 32'd0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_done",  32'(done),          32'd0);
    chk("rst_wdone", 32'(words_done),    32'd0);
    chk("rst_addr",  32'(bus.address),   32'd0);
    chk("rst_read",  32'(bus.read),      32'd0);
    chk("rst_write", 32'(bus.write),     32'd0);
    chk("rst_wdata", bus.writedata,      32'd0);
    @(negedge clk);
    #3 reset_n = 1'b1;

    // Zero-wait 4-word copy: done lands 13 cycles after the accepting edge.
    run_copy(4'd0, 4'd8, 4, dc);
    chk("t1_done_cycle", 32'(dc), 32'd13);
    chk("t1_words_done", 32'(words_done), 32'd4);
    chk("t1_txn_count", 32'(log_q.size()), 32'd8);
    chk("t1_mem8",  mem[8],  32'h11111111);
    chk("t1_mem9",  mem[9],  32'h22222222);
    chk("t1_mem10", mem[10], 32'h33333333);
    chk("t1_mem11", mem[11], 32'h44444444);

    // Random stalls and extra read latency, with overlapping regions.
    stress = 1;
    run_copy(4'd8, 4'd1, 5, dc);
    run_copy(4'd2, 4'd3, 3, dc);
    chk("t2_words_done", 32'(words_done), 32'd3);
    stress = 0;

    // Zero length: immediate done, no bus traffic.
    run_copy(4'd3, 4'd5, 0, dc);
    chk("t3_done_cycle", 32'(dc), 32'd1);
    chk("t3_no_bus", 32'(any_req), 32'd0);
    chk("t3_words_done", 32'(words_done), 32'd0);

    // Address wrap on a 4-bit bus.
    run_copy(4'd14, 4'd2, 4, dc);
    wrap_exp = '{14, 2, 15, 3, 0, 4, 1, 5};
    chk("t4_txn_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size()) chk($sformatf("t4_addr%0d", i), 32'(log_q[i]), 32'(wrap_exp[i]));
    end

    // Start pulsed mid-copy and spurious readdatavalid are both ignored.
    spurious = 1;
    fork
      run_copy(4'd5, 4'd10, 3, dc);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1; src_addr = 4'd0; dst_addr = 4'd0; length = 16'd7;
        @(negedge clk);
        start = 1'b0;
      end
    join
    spurious = 0;
    chk("t5_done_cycle", 32'(dc), 32'd10);
    chk("t5_words_done", 32'(words_done), 32'd3);

    // Reset asserted while a write is stalled; outputs must drop without a clock.
    hold_writes = 1;
    @(negedge clk);
    model_push(4'd0, 4'd12, 3, 1'b0);
    src_addr = 4'd0; dst_addr = 4'd12; length = 16'd3; start = 1'b1;
    @(posedge clk);
    w_acc = 0;
    #1 start = 1'b0;
    k = 0;
    while (!bus.write && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.write) fail_now("t6_write_timeout", "write request never presented");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_write_async", 32'(bus.write),   32'd0);
    chk("t6_read_async",  32'(bus.read),    32'd0);
    chk("t6_busy_async",  32'(busy),        32'd0);
    chk("t6_addr_async",  32'(bus.address), 32'd0);
    chk("t6_wdata_async", bus.writedata,    32'd0);
    hold_writes = 0;
    @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("t6_idle_busy",  32'(busy),       32'd0);
    chk("t6_idle_read",  32'(bus.read),   32'd0);
    chk("t6_idle_wdone", 32'(words_done), 32'd0);
    run_copy(4'd6, 4'd1, 2, dc);
    chk("t6_done_cycle", 32'(dc), 32'd7);
    chk("t6_words_done", 32'(words_done), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
